// File: rtl/sdram_init_sequencer.sv
// sdram_init_sequencer
//   SDRAM power-up sequencer and refresh-request timer. Holds the device in
//   INHIBIT until the PLL has been locked for LOCK_STABLE consecutive cycles.
//   It then runs power-up NOPs, PRECHARGE ALL, REFRESH_CNT auto-refreshes and
//   LOAD MODE. After that it raises init_done and produces periodic refresh
//   requests. Losing PLL lock restarts everything except the sticky overrun.
//   TRP, TRFC and TMRD must each be at least 2.
//
// Ports
//   clk         in   SDRAM controller clock
//   rst         in   synchronous active-high reset
//   pll_locked  in   PLL lock, synchronous to clk
//   cmd         out  {cs_n, ras_n, cas_n, we_n}
//   addr        out  SDRAM address bus
//   ba          out  bank address
//   cke         out  SDRAM clock enable
//   init_done   out  init complete
//   ref_req     out  refresh due (level, held until ref_ack)
//   ref_ack     in   controller issued the refresh
//   ref_overrun out  sticky: interval elapsed with ref_req still pending
module sdram_init_sequencer #(
  parameter int unsigned LOCK_STABLE      = 16,
  parameter int unsigned POWERUP_CYCLES   = 7421,
  parameter int unsigned TRP              = 2,
  parameter int unsigned TRFC             = 7,
  parameter int unsigned TMRD             = 2,
  parameter int unsigned REFRESH_CNT      = 8,
  parameter logic [12:0] MODE_VALUE       = 13'h030,
  parameter int unsigned REFRESH_INTERVAL = 578
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pll_locked,
  output logic [3:0]  cmd,
  output logic [12:0] addr,
  output logic [1:0]  ba,
  output logic        cke,
  output logic        init_done,
  output logic        ref_req,
  input  logic        ref_ack,
  output logic        ref_overrun
);

  localparam logic [3:0] CMD_INHIBIT = 4'b1111;
  localparam logic [3:0] CMD_NOP     = 4'b0111;
  localparam logic [3:0] CMD_PRE     = 4'b0010;
  localparam logic [3:0] CMD_AREF    = 4'b0001;
  localparam logic [3:0] CMD_LMR     = 4'b0000;

  localparam int unsigned WMAX0 = (POWERUP_CYCLES > TRFC) ? POWERUP_CYCLES : TRFC;
  localparam int unsigned WMAX1 = (WMAX0 > TRP) ? WMAX0 : TRP;
  localparam int unsigned WMAX  = (WMAX1 > TMRD) ? WMAX1 : TMRD;

  localparam int unsigned LCW = $clog2(LOCK_STABLE + 1);
  localparam int unsigned WCW = $clog2(WMAX + 1);
  localparam int unsigned RTW = $clog2(REFRESH_INTERVAL + 1);

  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_STABLE - 1);
  localparam logic [WCW-1:0] PU_LAST   = WCW'(POWERUP_CYCLES - 1);
  // Wait states pad (T - 1) cycles after the one-cycle command state.
  localparam logic [WCW-1:0] TRP_LAST  = WCW'(TRP - 2);
  localparam logic [WCW-1:0] TRFC_LAST = WCW'(TRFC - 2);
  localparam logic [WCW-1:0] TMRD_LAST = WCW'(TMRD - 2);
  localparam logic [3:0]     REF_TOTAL = 4'(REFRESH_CNT);
  localparam logic [RTW-1:0] RT_LAST   = RTW'(REFRESH_INTERVAL - 1);

  typedef enum logic [3:0] {
    S_WAIT_LOCK,
    S_POWERUP,
    S_PRECHARGE,
    S_WAIT_TRP,
    S_REFRESH,
    S_WAIT_TRFC,
    S_LOAD_MODE,
    S_WAIT_TMRD,
    S_DONE
  } state_t;

  state_t         r_state, w_state_nx;
  logic [LCW-1:0] r_lock_cnt, w_lock_nx;
  logic [WCW-1:0] r_wait_cnt, w_wait_nx;
  logic [3:0]     r_ref_cnt, w_ref_nx;
  logic [RTW-1:0] r_rtimer, w_rtimer_nx;
  logic           r_ref_req, w_ref_req_nx;
  logic           r_ref_overrun, w_ref_overrun_nx;
  logic           w_wrap;

  logic [3:0]     r_cmd, w_cmd_nx;
  logic [12:0]    r_addr, w_addr_nx;
  logic [1:0]     r_ba, w_ba_nx;
  logic           r_cke, w_cke_nx;
  logic           r_init_done, w_init_done_nx;

  always_comb begin
    w_state_nx       = r_state;
    w_lock_nx        = r_lock_cnt;
    w_wait_nx        = r_wait_cnt;
    w_ref_nx         = r_ref_cnt;
    w_rtimer_nx      = r_rtimer;
    w_ref_req_nx     = r_ref_req;
    w_ref_overrun_nx = r_ref_overrun;
    w_wrap           = (r_rtimer == RT_LAST);

    case (r_state)
      S_WAIT_LOCK: begin
        if (pll_locked) begin
          if (r_lock_cnt == LOCK_LAST) begin
            w_state_nx = S_POWERUP;
            w_lock_nx  = '0;
            w_wait_nx  = '0;
          end else begin
            w_lock_nx = r_lock_cnt + LCW'(1);
          end
        end else begin
          w_lock_nx = '0;
        end
      end
      S_POWERUP: begin
        if (r_wait_cnt == PU_LAST) begin
          w_state_nx = S_PRECHARGE;
          w_wait_nx  = '0;
        end else begin
          w_wait_nx = r_wait_cnt + WCW'(1);
        end
      end
      S_PRECHARGE: begin
        w_state_nx = S_WAIT_TRP;
        w_wait_nx  = '0;
      end
      S_WAIT_TRP: begin
        if (r_wait_cnt == TRP_LAST) begin
          w_state_nx = S_REFRESH;
          w_wait_nx  = '0;
        end else begin
          w_wait_nx = r_wait_cnt + WCW'(1);
        end
      end
      S_REFRESH: begin
        w_state_nx = S_WAIT_TRFC;
        w_wait_nx  = '0;
        w_ref_nx   = r_ref_cnt + 4'd1;
      end
      S_WAIT_TRFC: begin
        if (r_wait_cnt == TRFC_LAST) begin
          w_state_nx = (r_ref_cnt == REF_TOTAL) ? S_LOAD_MODE : S_REFRESH;
          w_wait_nx  = '0;
        end else begin
          w_wait_nx = r_wait_cnt + WCW'(1);
        end
      end
      S_LOAD_MODE: begin
        w_state_nx = S_WAIT_TMRD;
        w_wait_nx  = '0;
      end
      S_WAIT_TMRD: begin
        if (r_wait_cnt == TMRD_LAST) begin
          w_state_nx  = S_DONE;
          w_wait_nx   = '0;
          w_rtimer_nx = '0;
        end else begin
          w_wait_nx = r_wait_cnt + WCW'(1);
        end
      end
      S_DONE: begin
        w_rtimer_nx = w_wrap ? '0 : r_rtimer + RTW'(1);
        // A wrap takes priority over a same-cycle ack; only an unacked
        // pending request at the wrap counts as an overrun.
        if (w_wrap) begin
          if (r_ref_req && !ref_ack) w_ref_overrun_nx = 1'b1;
          w_ref_req_nx = 1'b1;
        end else if (ref_ack) begin
          w_ref_req_nx = 1'b0;
        end
      end
      default: w_state_nx = S_WAIT_LOCK;
    endcase

    // Lock loss aborts everything except the sticky overrun flag.
    if (!pll_locked && r_state != S_WAIT_LOCK) begin
      w_state_nx   = S_WAIT_LOCK;
      w_lock_nx    = '0;
      w_wait_nx    = '0;
      w_ref_nx     = '0;
      w_rtimer_nx  = '0;
      w_ref_req_nx = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    w_cmd_nx       = CMD_INHIBIT;
    w_addr_nx      = '0;
    w_ba_nx        = '0;
    w_cke_nx       = 1'b0;
    w_init_done_nx = 1'b0;
    case (w_state_nx)
      S_WAIT_LOCK: ;
      S_PRECHARGE: begin
        w_cke_nx      = 1'b1;
        w_cmd_nx      = CMD_PRE;
        w_addr_nx[10] = 1'b1;
      end
      S_REFRESH: begin
        w_cke_nx = 1'b1;
        w_cmd_nx = CMD_AREF;
      end
      S_LOAD_MODE: begin
        w_cke_nx  = 1'b1;
        w_cmd_nx  = CMD_LMR;
        w_addr_nx = MODE_VALUE;
      end
      S_DONE: begin
        w_cke_nx       = 1'b1;
        w_cmd_nx       = CMD_NOP;
        w_init_done_nx = 1'b1;
      end
      default: begin
        w_cke_nx = 1'b1;
        w_cmd_nx = CMD_NOP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_WAIT_LOCK;
      r_lock_cnt    <= '0;
      r_wait_cnt    <= '0;
      r_ref_cnt     <= '0;
      r_rtimer      <= '0;
      r_ref_req     <= 1'b0;
      r_ref_overrun <= 1'b0;
      r_cmd         <= CMD_INHIBIT;
      r_addr        <= '0;
      r_ba          <= '0;
      r_cke         <= 1'b0;
      r_init_done   <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_lock_cnt    <= w_lock_nx;
      r_wait_cnt    <= w_wait_nx;
      r_ref_cnt     <= w_ref_nx;
      r_rtimer      <= w_rtimer_nx;
      r_ref_req     <= w_ref_req_nx;
      r_ref_overrun <= w_ref_overrun_nx;
      r_cmd         <= w_cmd_nx;
      r_addr        <= w_addr_nx;
      r_ba          <= w_ba_nx;
      r_cke         <= w_cke_nx;
      r_init_done   <= w_init_done_nx;
    end
  end

  assign cmd         = r_cmd;
  assign addr        = r_addr;
  assign ba          = r_ba;
  assign cke         = r_cke;
  assign init_done   = r_init_done;
  assign ref_req     = r_ref_req;
  assign ref_overrun = r_ref_overrun;

endmodule

// File: tb/tb_sdram_init_sequencer.sv
// tb_sdram_init_sequencer
//   Directed bench for sdram_init_sequencer with default parameters:
//   per-cycle vectors for reset and lock qualification, then hand-written
//   sequences for full init, refresh handshake, lock loss and mid-init reset.
module tb_sdram_init_sequencer;

  localparam int P = 7421;   // cycles from cke rise to PRECHARGE

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pll_locked = 1'b0;
  logic        ref_ack = 1'b0;
  logic [3:0]  cmd;
  logic [12:0] addr;
  logic [1:0]  ba;
  logic        cke;
  logic        init_done;
  logic        ref_req;
  logic        ref_overrun;

  int n_total = 0;
  int n_pass  = 0;

  sdram_init_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .cmd        (cmd),
    .addr       (addr),
    .ba         (ba),
    .cke        (cke),
    .init_done  (init_done),
    .ref_req    (ref_req),
    .ref_ack    (ref_ack),
    .ref_overrun(ref_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       lock;
    logic [3:0] cmd;
    logic       cke;
    logic       done;
    logic       req;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic l, input logic [3:0] c,
                              input logic k, input int n);
    vec_t v;
    v.rst = r; v.lock = l; v.cmd = c; v.cke = k; v.done = 1'b0; v.req = 1'b0;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Steps until cke rises; returns the number of edges taken.
  task automatic wait_cke(output int n);
    n = 0;
    while (cke !== 1'b1 && n < 100) begin
      step();
      n++;
    end
  endtask

  // Starts at the first cycle with cke=1 (c=0). Runs to init_done, or stops
  // at cycle abort_c when non-zero.
  task automatic check_init(input int abort_c);
    int npre, nref, nlm, nbad, last;
    npre = 0; nref = 0; nlm = 0; nbad = 0;
    last = (abort_c > 0) ? abort_c : P + 60;
    chk("c0_nop", {28'd0, cmd}, 32'h7);
    for (int c = 1; c <= last; c++) begin
      step();
      case (cmd)
        4'b0010: begin
          npre++;
          chk("pre_time", c, P);
          chk("pre_addr", {19'd0, addr}, 32'h400);
          chk("pre_ba", {30'd0, ba}, 0);
        end
        4'b0001: begin
          chk("aref_time", c, P + 2 + 7 * nref);
          nref++;
        end
        4'b0000: begin
          nlm++;
          chk("lmr_time", c, P + 58);
          chk("lmr_addr", {19'd0, addr}, 32'h030);
          chk("lmr_ba", {30'd0, ba}, 0);
        end
        4'b0111: ;
        default: nbad++;
      endcase
      if (cke !== 1'b1) nbad++;
      if (c < P + 60 && init_done !== 1'b0) nbad++;
    end
    chk("init_bad_cycles", nbad, 0);
    if (abort_c == 0) begin
      chk("pre_count", npre, 1);
      chk("aref_count", nref, 8);
      chk("lmr_count", nlm, 1);
      chk("init_done_rise", {31'd0, init_done}, 1);
      chk("done_cmd_nop", {28'd0, cmd}, 32'h7);
    end else begin
      chk("aref_before_abort", nref, 4);
    end
  endtask

  initial begin
    int n;

    // Reset with lock high, then 16 lock samples to cke.
    add(1'b1, 1'b1, 4'hF, 1'b0, 3);
    add(1'b0, 1'b1, 4'hF, 1'b0, 15);
    add(1'b0, 1'b1, 4'h7, 1'b1, 1);
    // Lock glitch after 10 highs restarts qualification.
    add(1'b1, 1'b0, 4'hF, 1'b0, 1);
    add(1'b0, 1'b1, 4'hF, 1'b0, 10);
    add(1'b0, 1'b0, 4'hF, 1'b0, 1);
    add(1'b0, 1'b1, 4'hF, 1'b0, 15);
    add(1'b0, 1'b1, 4'h7, 1'b1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      rst        = vecs[i].rst;
      pll_locked = vecs[i].lock;
      step();
      chk($sformatf("vec%0d", i),
          {25'd0, cmd, cke, init_done, ref_req},
          {25'd0, vecs[i].cmd, vecs[i].cke, vecs[i].done, vecs[i].req});
      if (vecs[i].rst) begin
        chk($sformatf("vec%0d_addr", i), {19'd0, addr}, 0);
        chk($sformatf("vec%0d_ovr", i), {31'd0, ref_overrun}, 0);
      end
    end

    check_init(0);   // now at D, first cycle of init_done

    // Normal handshake: request at D+578, ack at D+583.
    step_n(577);
    chk("req_before_first", {31'd0, ref_req}, 0);
    step();
    chk("req_first", {31'd0, ref_req}, 1);
    step_n(5);
    chk("req_held", {31'd0, ref_req}, 1);
    ref_ack = 1'b1;
    step();
    ref_ack = 1'b0;
    chk("req_cleared", {31'd0, ref_req}, 0);
    step_n(571);
    chk("req_before_second", {31'd0, ref_req}, 0);
    step();
    chk("req_second", {31'd0, ref_req}, 1);

    // Ack on the wrap cycle: set wins, no overrun.
    step_n(577);
    ref_ack = 1'b1;
    step();
    ref_ack = 1'b0;
    chk("ack_on_wrap_req", {31'd0, ref_req}, 1);
    chk("ack_on_wrap_ovr", {31'd0, ref_overrun}, 0);

    // Never ack: next wrap flags overrun.
    step_n(577);
    chk("ovr_before_wrap", {31'd0, ref_overrun}, 0);
    chk("req_pending", {31'd0, ref_req}, 1);
    step();
    chk("ovr_set", {31'd0, ref_overrun}, 1);
    chk("ovr_req_held", {31'd0, ref_req}, 1);

    // Lock loss in DONE with a pending request.
    pll_locked = 1'b0;
    step();
    chk("loss_out", {25'd0, cmd, cke, init_done, ref_req}, {25'd0, 4'hF, 3'b000});
    chk("loss_ovr_kept", {31'd0, ref_overrun}, 1);
    pll_locked = 1'b1;
    wait_cke(n);
    chk("relock_latency", n, 16);
    check_init(0);

    // Reset during WAIT_TRFC of the 4th refresh, then full restart.
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    wait_cke(n);
    chk("relock2_latency", n, 16);
    check_init(P + 25);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_out", {25'd0, cmd, cke, init_done, ref_req}, {25'd0, 4'hF, 3'b000});
    chk("rst_addr_ba", {17'd0, addr, ba}, 0);
    chk("rst_ovr", {31'd0, ref_overrun}, 0);
    wait_cke(n);
    chk("rst_lock_latency", n, 16);
    check_init(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
